vga_timing: RTL

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_timing_if.sv | 37 +++
 rtl/vga_timing.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/vga_timing_if.sv
//------------------------------------------------------------------------------
// vga_timing_if : PLL lock input and registered raster outputs of vga_timing.
// Optional frame_count under VGA_TIMING_FRAME_COUNT_EN.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface vga_timing_if;
  logic       locked;
  logic       hsync;
  logic       vsync;
  logic       active;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       line_start;
  logic       frame_start;
`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [7:0] frame_count;
`endif

  modport master (
`ifdef VGA_TIMING_FRAME_COUNT_EN
    output frame_count,
`endif
    input  locked,
    output hsync, vsync, active, pixel_x, pixel_y, line_start, frame_start
  );

  modport slave (
`ifdef VGA_TIMING_FRAME_COUNT_EN
    input  frame_count,
`endif
    output locked,
    input  hsync, vsync, active, pixel_x, pixel_y, line_start, frame_start
  );
endinterface

`default_nettype wire

// File: rtl/vga_timing.sv
//------------------------------------------------------------------------------
// vga_timing : VGA raster counters with registered syncs/pixel coordinates.
// Optional 8-bit frame counter under VGA_TIMING_FRAME_COUNT_EN.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vga_timing #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FRONT  = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BACK   = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FRONT  = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BACK   = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic         clock,
  input  logic         reset,
  vga_timing_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] c_H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] c_H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] c_HS_BEG   = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] c_HS_END   = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] c_V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] c_V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] c_VS_BEG   = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] c_VS_END   = VW'(V_ACTIVE + V_FRONT + V_SYNC);

  localparam logic [1:0] c_PH_ACTIVE = 2'd0;
  localparam logic [1:0] c_PH_FRONT  = 2'd1;
  localparam logic [1:0] c_PH_SYNC   = 2'd2;
  localparam logic [1:0] c_PH_BACK   = 2'd3;

  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic          r_run;
  logic [1:0]    w_hph;
  logic [1:0]    w_vph;
  logic          w_en;
  logic          w_active;
  logic          w_hsync;
  logic          w_vsync;
  logic [9:0]    w_px;
  logic [9:0]    w_py;
  logic          w_line_start;
  logic          w_frame_start;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_active;
  logic [9:0]    r_px;
  logic [9:0]    r_py;
  logic          r_line_start;
  logic          r_frame_start;

  // r_run lags locked by one edge so (0,0) appears on the second edge after
  // lock; it resets high so counting starts on the first edge after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_h   <= '0;
      r_v   <= '0;
      r_run <= 1'b1;
    end else begin
      r_run <= vga.locked;
      if (!vga.locked) begin
        r_h <= '0;
        r_v <= '0;
      end else if (r_run) begin
        if (r_h == c_H_LAST) begin
          r_h <= '0;
          r_v <= (r_v == c_V_LAST) ? '0 : r_v + 1'b1;
        end else begin
          r_h <= r_h + 1'b1;
        end
      end
    end
  end

  always_comb begin
    if (r_h < c_H_ACT)       w_hph = c_PH_ACTIVE;
    else if (r_h < c_HS_BEG) w_hph = c_PH_FRONT;
    else if (r_h < c_HS_END) w_hph = c_PH_SYNC;
    else                     w_hph = c_PH_BACK;

    if (r_v < c_V_ACT)       w_vph = c_PH_ACTIVE;
    else if (r_v < c_VS_BEG) w_vph = c_PH_FRONT;
    else if (r_v < c_VS_END) w_vph = c_PH_SYNC;
    else                     w_vph = c_PH_BACK;
  end

  always_comb begin
    w_en          = vga.locked && r_run;
    w_active      = w_en && (w_hph == c_PH_ACTIVE) && (w_vph == c_PH_ACTIVE);
    w_hsync       = (w_en && (w_hph == c_PH_SYNC)) ? SYNC_POL : ~SYNC_POL;
    w_vsync       = (w_en && (w_vph == c_PH_SYNC)) ? SYNC_POL : ~SYNC_POL;
    w_px          = w_active ? 10'(r_h) : 10'd0;
    w_py          = w_active ? 10'(r_v) : 10'd0;
    w_line_start  = w_active && (r_h == '0);
    w_frame_start = w_line_start && (r_v == '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_active      <= 1'b0;
      r_px          <= '0;
      r_py          <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hsync       <= w_hsync;
      r_vsync       <= w_vsync;
      r_active      <= w_active;
      r_px          <= w_px;
      r_py          <= w_py;
      r_line_start  <= w_line_start;
      r_frame_start <= w_frame_start;
    end
  end

  assign vga.hsync       = r_hsync;
  assign vga.vsync       = r_vsync;
  assign vga.active      = r_active;
  assign vga.pixel_x     = r_px;
  assign vga.pixel_y     = r_py;
  assign vga.line_start  = r_line_start;
  assign vga.frame_start = r_frame_start;

`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [7:0] r_frame_count;

  // Steps on the edge after the frame_start cycle, so frame N shows count N.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_frame_count <= '0;
    end else if (!w_en) begin
      r_frame_count <= '0;
    end else if (r_frame_start) begin
      r_frame_count <= r_frame_count + 8'd1;
    end
  end

  assign vga.frame_count = r_frame_count;
`endif

endmodule

`default_nettype wire
